// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_wb
// Purpose  : 2-read / 1-write register file with optional same-cycle bypass
//            and hardwired-zero register 0.
// Revision : 1.0
// ============================================================================
module reg_file_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic [7:0]            write_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [7:0]            count;
    logic                  commit;

    // A write to the hardwired-zero register is not a write at all: it neither
    // updates storage, counts, nor bypasses.
    assign commit = reg_write && !((ZERO_REG != 0) && (write_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            count <= '0;
        end else if (commit) begin
            regs[write_addr] <= write_data;
            if (count != 8'hFF) begin
                count <= count + 8'd1;
            end
        end
    end

    always_comb begin
        read_data1 = regs[read_addr1];
        if ((BYPASS != 0) && commit && (read_addr1 == write_addr)) begin
            read_data1 = write_data;
        end
        if (rst || ((ZERO_REG != 0) && (read_addr1 == '0))) begin
            read_data1 = '0;
        end
    end

    always_comb begin
        read_data2 = regs[read_addr2];
        if ((BYPASS != 0) && commit && (read_addr2 == write_addr)) begin
            read_data2 = write_data;
        end
        if (rst || ((ZERO_REG != 0) && (read_addr2 == '0))) begin
            read_data2 = '0;
        end
    end

    assign write_count = count;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_wb
// Purpose  : Self-checking bench for reg_file_wb; runs a bypass/zero-reg
//            instance and a plain instance side by side on shared stimulus.
// Revision : 1.0
// ============================================================================
module tb_reg_file_wb;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic [7:0]  cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    // Reference state: "a" is BYPASS=1/ZERO_REG=1, "b" is BYPASS=0/ZERO_REG=0
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    int          wc_a;
    int          wc_b;

    reg_file_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .reg_write(reg_write), .write_addr(write_addr),
        .write_data(write_data), .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_data1(rd1_a), .read_data2(rd2_a), .write_count(cnt_a)
    );

    reg_file_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .reg_write(reg_write), .write_addr(write_addr),
        .write_data(write_data), .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_data1(rd1_b), .read_data2(rd2_b), .write_count(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] ea1;
        logic [31:0] ea2;
        logic [31:0] eb1;
        logic [31:0] eb2;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [31:0] exp_a(input logic [4:0] a);
        if (rst || a == 5'd0) return 32'd0;
        if (reg_write && a == write_addr) return write_data;
        return mem_a[a];
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] a);
        if (rst) return 32'd0;
        return mem_b[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " a.rd1"}, rd1_a, exp_a(read_addr1));
        chk({tag, " a.rd2"}, rd2_a, exp_a(read_addr2));
        chk({tag, " a.cnt"}, {24'd0, cnt_a}, wc_a[31:0]);
        chk({tag, " b.rd1"}, rd1_b, exp_b(read_addr1));
        chk({tag, " b.rd2"}, rd2_b, exp_b(read_addr2));
        chk({tag, " b.cnt"}, {24'd0, cnt_b}, wc_b[31:0]);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 32'd0;
            mem_b[i] = 32'd0;
        end
        wc_a = 0;
        wc_b = 0;
    endtask

    // Advance one clock; the model commits with the inputs seen at the edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (reg_write) begin
            if (write_addr != 5'd0) begin
                mem_a[write_addr] = write_data;
                if (wc_a < 255) wc_a++;
            end
            mem_b[write_addr] = write_data;
            if (wc_b < 255) wc_b++;
        end
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        reg_write  = we;
        write_addr = wa;
        write_data = wd;
        read_addr1 = ra1;
        read_addr2 = ra2;
        #1;
    endtask

    initial begin
        logic [31:0] last;

        vecs[0] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd7,  32'h12345678, 32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b1, 5'd7,  32'h0000ABCD, 5'd31, 5'd7,  32'h12345678, 32'h0000ABCD, 32'h12345678, 32'h0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'h12345678, 32'h0000ABCD, 32'h12345678, 32'h0000ABCD};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5] = '{1'b1, 5'd3,  32'h11,       5'd3,  5'd3,  32'h11,       32'h11,       32'h0,        32'h0};
        vecs[6] = '{1'b1, 5'd3,  32'h22,       5'd3,  5'd3,  32'h22,       32'h22,       32'h11,       32'h11};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'h22,       32'h22,       32'h22,       32'h22};

        model_clear();
        rst = 1'b1;
        drive(1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd0);
        chk("reset rd1 no bypass", rd1_a, 32'd0);
        chk("reset cnt", {24'd0, cnt_a}, 32'd0);
        step();
        step();
        chk_model("in reset");
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        // Directed table: write/read, zero register, bypass vs. no bypass
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
            chk($sformatf("vec%0d a.rd1", i), rd1_a, vecs[i].ea1);
            chk($sformatf("vec%0d a.rd2", i), rd2_a, vecs[i].ea2);
            chk($sformatf("vec%0d b.rd1", i), rd1_b, vecs[i].eb1);
            chk($sformatf("vec%0d b.rd2", i), rd2_b, vecs[i].eb2);
            step();
        end
        chk("table a.cnt", {24'd0, cnt_a}, 32'd4);
        chk("table b.cnt", {24'd0, cnt_b}, 32'd5);

        // Write-enable gating: random addr/data with reg_write low
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
            step();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            chk_model("gated");
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            logic [4:0] wa;
            wa = 5'($urandom);
            drive(1'($urandom), wa, $urandom,
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom),
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom));
            chk_model("random");
            step();
        end

        // Saturation: 300 writes to r9
        last = 32'd0;
        for (int i = 0; i < 300; i++) begin
            last = $urandom;
            drive(1'b1, 5'd9, last, 5'd9, 5'd1);
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
        chk("sat a.cnt", {24'd0, cnt_a}, 32'd255);
        chk("sat b.cnt", {24'd0, cnt_b}, 32'd255);
        chk("sat r9 last", rd1_a, last);
        chk_model("sat");

        // Asynchronous reset between edges
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        chk("pre-rst r5", rd1_a, 32'hDEADBEEF);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        #1;
        chk("async rst r5", rd1_a, 32'd0);
        chk("async rst b.r5", rd1_b, 32'd0);
        chk("async rst cnt", {24'd0, cnt_a}, 32'd0);
        step();
        rst = 1'b0;
        drive(1'b1, 5'd4, 32'h00000033, 5'd4, 5'd4);
        step();

        // Reset racing a write to r4
        drive(1'b1, 5'd4, 32'h00000055, 5'd4, 5'd4);
        rst = 1'b1;
        #1;
        chk("race rd bypass suppressed", rd1_a, 32'd0);
        step();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd4);
        chk("race r4 a", rd1_a, 32'd0);
        chk("race r4 b", rd2_b, 32'd0);
        chk_model("after race");
        drive(1'b1, 5'd4, 32'h00000077, 5'd4, 5'd4);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd4);
        chk("post-race r4 a", rd1_a, 32'h77);
        chk("post-race r4 b", rd2_b, 32'h77);
        chk("post-race cnt", {24'd0, cnt_a}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32-entry general-purpose register file for the single-cycle RISC datapath.
- It is the consumer of the 5-bit destination-register select and the write-back data from the write-back mux stage.
- It provides two combinational read ports to the decode/ALU stage and one synchronous write port.
- Optional same-cycle write-to-read bypass and a hardwired-zero register are parameter-controlled.

Parameters:
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: address width. The file holds 2**ADDR_WIDTH entries.
- BYPASS, 1: 1 means a read port returns write_data when it addresses the register being written this cycle. 0 means it returns the stored value.
- ZERO_REG, 1: 1 means register 0 always reads 0 and writes to it are ignored. 0 means register 0 is ordinary.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears every register.
- reg_write  input  1  write enable for the current cycle.
- write_addr  input  ADDR_WIDTH  destination register index (from the destination-select mux).
- write_data  input  DATA_WIDTH  write-back value.
- read_addr1  input  ADDR_WIDTH  read port 1 index.
- read_addr2  input  ADDR_WIDTH  read port 2 index.
- read_data1  output  DATA_WIDTH  read port 1 data (combinational).
- read_data2  output  DATA_WIDTH  read port 2 data (combinational).
- write_count  output  8  saturating count of committed writes, for verification visibility.

Behaviour:
- Reset:
  - While rst is high, all entries are 0 and write_count is 0.
  - read_data1 and read_data2 read 0 for every address; bypass is suppressed during reset.
  - Assertion is asynchronous: state clears without waiting for a clk edge.
  - Deassertion: the first write can commit on the first rising edge after rst falls.
- Write:
  - On a rising clk edge with rst low and reg_write high, entry[write_addr] takes write_data.
  - Latency is 1 cycle; the new value is visible on a non-bypassed read immediately after that edge.
- Ignored writes:
  - reg_write low: no entry changes, whatever write_addr and write_data are.
  - ZERO_REG=1 and write_addr==0: the write is discarded and write_count does not increment.
- write_count:
  - Increments by 1 on each committed write.
  - Saturates at 255; it does not wrap.
- Read:
  - read_dataN equals entry[read_addrN], combinationally, with zero-cycle latency.
  - ZERO_REG=1 and read_addrN==0: output is 0 regardless of bypass.
- Bypass (BYPASS=1):
  - If reg_write is high, rst is low, and read_addrN==write_addr (and that address is not the discarded zero register), read_dataN equals write_data in the same cycle.
  - The two ports bypass independently. Both ports may address the same register, and both bypass.
- Simultaneous events:
  - A write and a read of the same address with BYPASS=0 returns the old value until the edge.
  - A back-to-back write to the same address in consecutive cycles: the last write wins.
- Reset mid-operation:
  - rst asserted in the same cycle as a reg_write edge: reset wins and the entry ends at 0.
  - A write in flight is lost, not deferred.
- X handling: write_addr and write_data are don't-care when reg_write is low. The file must not latch on them.

Test Plan:
- Reset clears state:
  - Write 0xDEADBEEF to r5, then assert rst asynchronously between edges.
  - read_data1 at r5 goes to 0 before the next edge; write_count=0.
- Basic write/read:
  - Write 0x12345678 to r31 (link-register destination), then 0x0000ABCD to r7.
  - Next cycle: read1=r31 gives 0x12345678 and read2=r7 gives 0x0000ABCD; write_count=2.
- Zero register:
  - With ZERO_REG=1, write 0xFFFFFFFF to r0.
  - read1=r0 gives 0, both in the same cycle (bypass) and after; write_count is unchanged.
- Bypass, BYPASS=1:
  - r3 holds 0x11; in the write cycle, reg_write=1, write_addr=3, write_data=0x22, read_addr1=3, read_addr2=3.
  - Both outputs give 0x22 before the edge.
  - With BYPASS=0, the same stimulus gives 0x11 before the edge and 0x22 after.
- Write-enable gating and saturation:
  - 10 cycles with reg_write=0 and random address/data leave all entries unchanged.
  - 300 writes to r9 give write_count=255 and r9 holding the last value written.
- Reset racing a write:
  - rst rises in the same cycle as a write of 0x55 to r4.
  - r4 reads 0 after rst falls; the next write to r4 commits normally.
